// File: rtl/wb_frame_pkg.sv
// Shared types and constants for the Wishbone frame reader.
package wb_frame_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        REQ   = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;
endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle; master drives cyc/stb/we/sel/adr/dat_ms.
interface wshb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;

    modport master (output cyc, stb, we, sel, adr, dat_ms, input dat_sm, ack);
    modport slave  (input cyc, stb, we, sel, adr, dat_ms, output dat_sm, ack);
endinterface

// File: rtl/wb_frame_fifo.sv
// Small synchronous FIFO with a combinational head and a free-entry count.
module wb_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   free_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign free_cnt = (AW+1)'(DEPTH) - count;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/wb_frame_reader.sv
// Wishbone classic read master streaming a frame of words through a FIFO.
module wb_frame_reader
    import wb_frame_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    wshb_if.master           wb_m,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic [31:0]      base_adr,
    input  logic [CNT_W-1:0] nwords,
    output logic             busy,
    output logic             done,
    output logic [31:0]      out_data,
    output logic             out_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output state_t           dbg_state
);
    // Stream handshake: a word moves when out_valid && out_ready on a rising
    // edge; while out_valid && !out_ready the head (data and sof) stays put.
    state_t                     state;
    logic                       cyc_r;
    logic [31:0]                adr_r;
    logic [31:0]                base_r;
    logic [CNT_W-1:0]           nwords_r;
    logic [CNT_W-1:0]           cnt;
    logic                       cont_r;
    logic                       sof_flag;
    logic                       last;
    logic                       push;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [32:0]                fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] free_cnt;

    assign wb_m.cyc    = cyc_r;
    assign wb_m.stb    = cyc_r;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = WB_SEL_ALL;
    assign wb_m.adr    = adr_r;
    assign wb_m.dat_ms = 32'h0;

    assign push      = (state == REQ) && wb_m.ack;
    assign out_valid = !fifo_empty;
    assign out_sof   = fifo_dout[32];
    assign out_data  = fifo_dout[31:0];
    assign dbg_state = state;

    wb_frame_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(33)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .din      ({sof_flag, wb_m.dat_sm}),
        .pop      (out_valid && out_ready),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .free_cnt (free_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cyc_r    <= 1'b0;
            adr_r    <= 32'h0;
            base_r   <= 32'h0;
            nwords_r <= '0;
            cnt      <= '0;
            cont_r   <= 1'b0;
            sof_flag <= 1'b0;
            last     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (nwords != '0) begin
                            base_r   <= {base_adr[31:2], 2'b00};
                            nwords_r <= nwords;
                            cont_r   <= cont;
                            cnt      <= '0;
                            sof_flag <= 1'b1;
                            last     <= 1'b0;
                            busy     <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (stop) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (free_cnt != '0) begin
                        cyc_r <= 1'b1;
                        adr_r <= base_r + 32'({cnt, 2'b00});
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (wb_m.ack) begin
                        cyc_r    <= 1'b0;
                        sof_flag <= 1'b0;
                        state    <= GAP;
                        if (cnt == nwords_r - CNT_W'(1)) begin
                            if (cont_r) begin
                                cnt      <= '0;
                                sof_flag <= 1'b1;
                            end else begin
                                last <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (last || stop) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_frame_reader.sv
// Directed bench for wb_frame_reader with a registered-ack Wishbone slave model.
module tb_wb_frame_reader;
    import wb_frame_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cont = 1'b0;
    logic [31:0] base_adr = 32'h0;
    logic [15:0] nwords = 16'h0;
    logic        busy;
    logic        done;
    logic [31:0] out_data;
    logic        out_sof;
    logic        out_valid;
    logic        out_ready = 1'b1;
    state_t      dbg_state;

    int total = 0;
    int bad = 0;

    wshb_if wb ();

    wb_frame_reader #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_m      (wb),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .base_adr  (base_adr),
        .nwords    (nwords),
        .busy      (busy),
        .done      (done),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Slave: acks wait_n cycles after first seeing stb, data = ~adr.
    int wait_n = 0;
    int wcnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.ack    <= 1'b0;
            wb.dat_sm <= 32'h0;
            wcnt      <= 0;
        end else begin
            wb.ack <= 1'b0;
            if (wb.cyc && wb.stb && !wb.ack) begin
                if (wcnt >= wait_n) begin
                    wb.ack    <= 1'b1;
                    wb.dat_sm <= ~wb.adr;
                    wcnt      <= 0;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // Scoreboard logs, captured mid-cycle.
    logic [31:0] adr_log[$];
    logic [32:0] out_log[$];
    logic [31:0] exp_adr_q[$];
    logic [32:0] exp_q[$];
    int          done_cnt = 0;
    bit          cyc_seen = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wb.cyc && wb.stb && wb.ack) adr_log.push_back(wb.adr);
            if (out_valid && out_ready)     out_log.push_back({out_sof, out_data});
            if (done)                       done_cnt++;
            if (wb.cyc)                     cyc_seen = 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        adr_log.delete();
        out_log.delete();
        exp_adr_q.delete();
        exp_q.delete();
        done_cnt = 0;
        cyc_seen = 0;
    endtask

    task automatic start_run(input logic [31:0] b, input logic [15:0] n, input logic c);
        base_adr = b;
        nwords   = n;
        cont     = c;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Expected words: addresses cycle through the frame, sof at each frame start.
    task automatic expect_frame(input logic [31:0] b, input int n, input int words);
        for (int i = 0; i < words; i++) begin
            logic [31:0] a;
            a = b + 32'(4 * (i % n));
            exp_adr_q.push_back(a);
            exp_q.push_back({(i % n) == 0, ~a});
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400 && done_cnt == 0; i++) step();
        if (done_cnt == 0) check({tag, "_done_timeout"}, 0, 1);
        for (int i = 0; i < 30 && out_valid; i++) step();
        step();
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_n_adr"}, adr_log.size(), exp_adr_q.size());
        for (int i = 0; i < adr_log.size() && i < exp_adr_q.size(); i++)
            check({tag, "_adr"}, adr_log[i], exp_adr_q[i]);
        check({tag, "_n_out"}, out_log.size(), exp_q.size());
        for (int i = 0; i < out_log.size() && i < exp_q.size(); i++)
            check({tag, "_word"}, out_log[i], exp_q[i]);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_cyc", wb.cyc, 0);
        check("rst_stb", wb.stb, 0);
        check("rst_we", wb.we, 0);
        check("rst_sel", wb.sel, 4'hF);
        check("rst_adr", wb.adr, 0);
        check("rst_dat_ms", wb.dat_ms, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        step();

        // 1: plain 4-word frame
        clear_logs();
        expect_frame(32'h100, 4, 4);
        start_run(32'h100, 16'd4, 1'b0);
        check("t1_busy_high", busy, 1);
        wait_done("t1");
        compare_logs("t1");
        check("t1_done_pulses", done_cnt, 1);
        check("t1_busy_low", busy, 0);

        // 2: backpressure fills the FIFO, then drains in order
        clear_logs();
        out_ready = 1'b0;
        expect_frame(32'h2000, 8, 8);
        start_run(32'h2001, 16'd8, 1'b0);
        repeat (40) step();
        check("t2_reads_at_full", adr_log.size(), 4);
        check("t2_stb_parked", wb.stb, 0);
        check("t2_valid", out_valid, 1);
        check("t2_head", {out_sof, out_data}, {1'b1, ~32'h2000});
        out_ready = 1'b1;
        wait_done("t2");
        compare_logs("t2");

        // 3: loop mode stopped after seven acks
        clear_logs();
        expect_frame(32'h300, 3, 7);
        start_run(32'h300, 16'd3, 1'b1);
        for (int i = 0; i < 200 && adr_log.size() < 7; i++) step();
        stop = 1'b1;
        wait_done("t3");
        stop = 1'b0;
        compare_logs("t3");

        // 4: stop while a stalled cycle is pending
        clear_logs();
        wait_n = 5;
        expect_frame(32'h400, 10, 1);
        start_run(32'h400, 16'd10, 1'b0);
        for (int i = 0; i < 20 && !wb.stb; i++) step();
        stop = 1'b1;
        step();
        check("t4_stb_hold1", wb.stb, 1);
        step();
        step();
        check("t4_stb_hold3", wb.stb, 1);
        wait_done("t4");
        stop = 1'b0;
        repeat (5) step();
        compare_logs("t4");
        check("t4_idle_cyc", wb.cyc, 0);
        wait_n = 0;

        // 5: empty frame, then start while busy
        clear_logs();
        start_run(32'h800, 16'd0, 1'b0);
        check("t5_done_next", done, 1);
        check("t5_busy_zero", busy, 0);
        step();
        check("t5_done_once", done, 0);
        repeat (3) step();
        check("t5_no_cyc", cyc_seen, 0);
        clear_logs();
        expect_frame(32'h500, 2, 2);
        start_run(32'h500, 16'd2, 1'b0);
        step();
        start_run(32'h900, 16'd5, 1'b1);
        wait_done("t5");
        compare_logs("t5");

        // 6: reset in the middle of a bus cycle
        clear_logs();
        out_ready = 1'b0;
        wait_n = 3;
        start_run(32'h600, 16'd4, 1'b0);
        for (int i = 0; i < 60 && !(adr_log.size() == 1 && wb.stb); i++) step();
        check("t6_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_cyc", wb.cyc, 0);
        check("t6_rst_stb", wb.stb, 0);
        check("t6_rst_valid", out_valid, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        wait_n = 0;
        step();
        clear_logs();
        expect_frame(32'h700, 2, 2);
        start_run(32'h700, 16'd2, 1'b0);
        wait_done("t6");
        compare_logs("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
